// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control unit.
// Five-state FSM (FETCH, DECODE, EXEC, MEM, WB) that sequences the shared
// datapath for addu, subu, ori, lui, lw, sw, beq and j. Anything else is a
// two-cycle NOP.
// Optional feature: define MC_CTRL_SLT_EN to decode slt (R-type funct 101010)
// as an R-type ALU op using the A-less-than-B ALU operation. With the macro
// undefined, slt decodes as NOP.
// ALU operation encodings normally come from Head.v. Defaults are provided
// here for any that are not already defined.

`ifndef ALUCtrl_Len
`define ALUCtrl_Len 4
`endif
`ifndef ALUCtrl_Add
`define ALUCtrl_Add 4'd0
`endif
`ifndef ALUCtrl_Sub
`define ALUCtrl_Sub 4'd1
`endif
`ifndef ALUCtrl_Or
`define ALUCtrl_Or 4'd3
`endif
`ifndef ALUCtrl_AlessB
`define ALUCtrl_AlessB 4'd4
`endif
`ifndef ALUCtrl_Undefined
`define ALUCtrl_Undefined 4'd15
`endif

module mc_ctrl (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              Opcode,
  input  logic [5:0]              Funct,
  input  logic                    ALUZero,
  output logic [`ALUCtrl_Len-1:0] ALUCtrl,
  output logic                    PCWrite,
  output logic                    IRWrite,
  output logic                    RegWrite,
  output logic                    MemWrite,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              RegDst,
  output logic [1:0]              MemtoReg,
  output logic [1:0]              PCSrc,
  output logic [2:0]              State,
  output logic                    InstrDone
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [3:0] CL_NOP  = 4'd0;
  localparam logic [3:0] CL_ADDU = 4'd1;
  localparam logic [3:0] CL_SUBU = 4'd2;
  localparam logic [3:0] CL_ORI  = 4'd3;
  localparam logic [3:0] CL_LUI  = 4'd4;
  localparam logic [3:0] CL_LW   = 4'd5;
  localparam logic [3:0] CL_SW   = 4'd6;
  localparam logic [3:0] CL_BEQ  = 4'd7;
  localparam logic [3:0] CL_J    = 4'd8;
  localparam logic [3:0] CL_SLT  = 4'd9;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_cls;
  logic [3:0] w_dec;
  logic [3:0] w_cls;

  // Instruction class decode from the IR fields.
  always_comb begin
    w_dec = CL_NOP;
    case (Opcode)
      6'b000000: begin
        case (Funct)
          6'b100001: w_dec = CL_ADDU;
          6'b100011: w_dec = CL_SUBU;
`ifdef MC_CTRL_SLT_EN
          6'b101010: w_dec = CL_SLT;
`endif
          default:   w_dec = CL_NOP;
        endcase
      end
      6'b001101: w_dec = CL_ORI;
      6'b001111: w_dec = CL_LUI;
      6'b100011: w_dec = CL_LW;
      6'b101011: w_dec = CL_SW;
      6'b000100: w_dec = CL_BEQ;
      6'b000010: w_dec = CL_J;
      default:   w_dec = CL_NOP;
    endcase
  end

  // The class register only loads at the end of DECODE, so DECODE itself
  // acts on the live decode of the freshly written IR.
  assign w_cls = (r_state == ST_DECODE) ? w_dec : r_cls;
  assign State = r_state;

  // State and class registers; reset drops straight to FETCH/NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_cls   <= CL_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_cls <= w_dec;
    end
  end

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = ((w_cls == CL_NOP) || (w_cls == CL_J)) ? ST_FETCH : ST_EXEC;
      ST_EXEC: begin
        if (w_cls == CL_BEQ)                         w_next = ST_FETCH;
        else if ((w_cls == CL_LW) || (w_cls == CL_SW)) w_next = ST_MEM;
        else                                         w_next = ST_WB;
      end
      ST_MEM:    w_next = (w_cls == CL_LW) ? ST_WB : ST_FETCH;
      ST_WB:     w_next = ST_FETCH;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Moore outputs from state and class; beq PCWrite follows ALUZero live.
  always_comb begin
    ALUCtrl   = `ALUCtrl_Undefined;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUSrcB   = 2'd0;
    RegDst    = 2'd0;
    MemtoReg  = 2'd0;
    PCSrc     = 2'd0;
    InstrDone = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = 2'd0;
          ALUCtrl = `ALUCtrl_Add;
        end
        ST_DECODE: begin
          if (w_cls == CL_J) begin
            PCWrite   = 1'b1;
            PCSrc     = 2'd2;
            InstrDone = 1'b1;
          end else if (w_cls == CL_NOP) begin
            InstrDone = 1'b1;
          end
        end
        ST_EXEC: begin
          case (w_cls)
            CL_ADDU: begin ALUCtrl = `ALUCtrl_Add;    ALUSrcB = 2'd0; end
            CL_SUBU: begin ALUCtrl = `ALUCtrl_Sub;    ALUSrcB = 2'd0; end
            CL_SLT:  begin ALUCtrl = `ALUCtrl_AlessB; ALUSrcB = 2'd0; end
            CL_ORI:  begin ALUCtrl = `ALUCtrl_Or;     ALUSrcB = 2'd2; end
            CL_LUI:  begin ALUCtrl = `ALUCtrl_Or;     ALUSrcB = 2'd3; end
            CL_LW, CL_SW: begin ALUCtrl = `ALUCtrl_Add; ALUSrcB = 2'd1; end
            CL_BEQ: begin
              ALUCtrl   = `ALUCtrl_Sub;
              ALUSrcB   = 2'd0;
              PCSrc     = 2'd1;
              PCWrite   = ALUZero;
              InstrDone = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (w_cls == CL_SW) begin
            MemWrite  = 1'b1;
            InstrDone = 1'b1;
          end
        end
        ST_WB: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          if (w_cls == CL_LW) begin
            RegDst   = 2'd0;
            MemtoReg = 2'd1;
          end else if ((w_cls == CL_ADDU) || (w_cls == CL_SUBU) || (w_cls == CL_SLT)) begin
            RegDst   = 2'd1;
            MemtoReg = 2'd0;
          end else begin
            RegDst   = 2'd0;
            MemtoReg = 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl.
// Each instruction is described as the sequence of per-cycle output words it
// must produce; a compare process checks the DUT against that sequence on
// every cycle while an instruction is in flight.

`ifndef ALUCtrl_Len
`define ALUCtrl_Len 4
`endif
`ifndef ALUCtrl_Add
`define ALUCtrl_Add 4'd0
`endif
`ifndef ALUCtrl_Sub
`define ALUCtrl_Sub 4'd1
`endif
`ifndef ALUCtrl_Or
`define ALUCtrl_Or 4'd3
`endif
`ifndef ALUCtrl_AlessB
`define ALUCtrl_AlessB 4'd4
`endif
`ifndef ALUCtrl_Undefined
`define ALUCtrl_Undefined 4'd15
`endif

module tb_mc_ctrl;

  localparam int AW = `ALUCtrl_Len;
  localparam int VW = 16 + AW;
  typedef logic [VW-1:0] vec_t;

  localparam logic [AW-1:0] A_ADD = `ALUCtrl_Add;
  localparam logic [AW-1:0] A_SUB = `ALUCtrl_Sub;
  localparam logic [AW-1:0] A_OR  = `ALUCtrl_Or;
  localparam logic [AW-1:0] A_LT  = `ALUCtrl_AlessB;
  localparam logic [AW-1:0] A_UND = `ALUCtrl_Undefined;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    Opcode = 6'd0;
  logic [5:0]    Funct = 6'd0;
  logic          ALUZero = 1'b0;
  logic [AW-1:0] ALUCtrl;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, InstrDone;
  logic [1:0]    ALUSrcB, RegDst, MemtoReg, PCSrc;
  logic [2:0]    State;

  int checks = 0;
  int errors = 0;
  vec_t q[$];
  vec_t act;
  vec_t reset_word;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .ALUZero(ALUZero),
    .ALUCtrl(ALUCtrl), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .PCSrc(PCSrc), .State(State), .InstrDone(InstrDone)
  );

  always #5 clk = ~clk;

  assign act = {State, PCWrite, IRWrite, RegWrite, MemWrite,
                ALUSrcB, RegDst, MemtoReg, PCSrc, ALUCtrl, InstrDone};

  task automatic check_vec(input string name, input vec_t a, input vec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  // One expected cycle: state, enables, selects, ALU op, done flag.
  task automatic push(input logic [2:0] st, input logic pcw, input logic irw,
                      input logic rw, input logic mw, input logic [1:0] srcb,
                      input logic [1:0] rdst, input logic [1:0] m2r,
                      input logic [1:0] pcsrc, input logic [AW-1:0] alu,
                      input logic done);
    q.push_back({st, pcw, irw, rw, mw, srcb, rdst, m2r, pcsrc, alu, done});
  endtask

  // Behaviour of one instruction, written as its full cycle sequence.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    string k;
    k = "nop";
    if (op == 6'b000000 && fn == 6'b100001) k = "addu";
    if (op == 6'b000000 && fn == 6'b100011) k = "subu";
`ifdef MC_CTRL_SLT_EN
    if (op == 6'b000000 && fn == 6'b101010) k = "slt";
`endif
    if (op == 6'b001101) k = "ori";
    if (op == 6'b001111) k = "lui";
    if (op == 6'b100011) k = "lw";
    if (op == 6'b101011) k = "sw";
    if (op == 6'b000100) k = "beq";
    if (op == 6'b000010) k = "j";
    // FETCH is common to every instruction
    push(3'd0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, A_ADD, 0);
    if (k == "nop") begin
      push(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, A_UND, 1);
    end else if (k == "j") begin
      push(3'd1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd2, A_UND, 1);
    end else begin
      push(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, A_UND, 0);
      if (k == "beq") begin
        push(3'd2, z, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, A_SUB, 1);
      end else if (k == "addu" || k == "subu" || k == "slt") begin
        push(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0,
             (k == "addu") ? A_ADD : ((k == "subu") ? A_SUB : A_LT), 0);
        push(3'd4, 0, 0, 1, 0, 2'd0, 2'd1, 2'd0, 2'd0, A_UND, 1);
      end else if (k == "ori" || k == "lui") begin
        push(3'd2, 0, 0, 0, 0, (k == "ori") ? 2'd2 : 2'd3, 2'd0, 2'd0, 2'd0, A_OR, 0);
        push(3'd4, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, A_UND, 1);
      end else if (k == "lw") begin
        push(3'd2, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, A_ADD, 0);
        push(3'd3, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, A_UND, 0);
        push(3'd4, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 2'd0, A_UND, 1);
      end else begin
        push(3'd2, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, A_ADD, 0);
        push(3'd3, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, A_UND, 1);
      end
    end
  endtask

  // Checks every in-flight cycle against the expected sequence.
  always @(negedge clk) begin
    if (!reset && q.size() > 0) begin
      check_vec("cycle", act, q.pop_front());
    end
  end

  // Called at posedge+1 in a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, input int exp_len);
    int n;
    bit seen;
    Opcode = op;
    Funct = fn;
    ALUZero = z;
    model(op, fn, z);
    n = 0;
    seen = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (InstrDone === 1'b1) seen = 1;
    end
    check_int({name, " cycles"}, n, exp_len);
    @(posedge clk);
    #1;
    check_int({name, " sequence drained"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_word = {3'd0, 4'b0000, 8'h00, A_UND, 1'b0};
    #1;
    check_vec("reset outputs", act, reset_word);
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset held", act, reset_word);
    reset = 1'b0;
    #1;
    check_int("release IRWrite", int'(IRWrite), 1);

    run_instr("addu", 6'b000000, 6'b100001, 1'b0, 4);
    run_instr("subu", 6'b000000, 6'b100011, 1'b0, 4);
    run_instr("ori",  6'b001101, 6'b010101, 1'b0, 4);
    run_instr("lui",  6'b001111, 6'b000000, 1'b1, 4);
    run_instr("beq taken",     6'b000100, 6'b000000, 1'b1, 3);
    run_instr("beq not taken", 6'b000100, 6'b000000, 1'b0, 3);
    run_instr("lw",   6'b100011, 6'b000000, 1'b0, 5);
    run_instr("sw",   6'b101011, 6'b000000, 1'b0, 4);
    run_instr("nop 111111", 6'b111111, 6'b000000, 1'b0, 2);
    run_instr("j",    6'b000010, 6'b000000, 1'b0, 2);
    run_instr("rtype unknown funct", 6'b000000, 6'b100000, 1'b0, 2);
`ifdef MC_CTRL_SLT_EN
    run_instr("slt", 6'b000000, 6'b101010, 1'b0, 4);
`else
    run_instr("slt", 6'b000000, 6'b101010, 1'b0, 2);
`endif

    // lw interrupted by reset in EXEC
    Opcode = 6'b100011;
    Funct = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_int("lw mid state", int'(State), 2);
    check_int("lw mid ALUSrcB", int'(ALUSrcB), 1);
    #2;
    reset = 1'b1;
    #1;
    check_vec("async reset in EXEC", act, reset_word);
    repeat (3) begin
      @(posedge clk); #1;
      check_vec("reset hold after lw", act, reset_word);
    end
    reset = 1'b0;
    #1;
    check_int("post-reset State", int'(State), 0);
    check_int("post-reset IRWrite", int'(IRWrite), 1);
    run_instr("addu after reset", 6'b000000, 6'b100001, 1'b0, 4);
    run_instr("sw after reset", 6'b101011, 6'b000000, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
